// File: rtl/ram_rr_arbiter_pkg.sv
// Shared types and constants for the two-client RAM round-robin arbiter.
package ram_rr_arbiter_pkg;

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_t;

    localparam int NUM_REQ = 2;
    // Cycles from the accept cycle to the rsp_valid cycle.
    localparam int RD_LAT  = 2;

endpackage

// File: rtl/ram_rr_arbiter_rr_arb2.sv
// Two-way round-robin grant with a registered priority pointer.
// state | meaning
// PRI0  | requester 0 wins when both are valid
// PRI1  | requester 1 wins when both are valid
module rr_arb2
    import ram_rr_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    pri_t ptr;
    pri_t ptr_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= PRI0;
        end else begin
            ptr <= ptr_next;
        end
    end

    // Grant is gated by rst_n so no command can slip in while reset is held.
    always_comb begin
        grant    = 2'b00;
        ptr_next = ptr;
        if (rst_n) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (ptr == PRI0) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
            if (grant[0]) begin
                ptr_next = PRI1;
            end else if (grant[1]) begin
                ptr_next = PRI0;
            end
        end
    end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Shares one single-port synchronous RAM between two clients; registers the
// winning command and returns read data to its originator two cycles later.
module ram_rr_arbiter
    import ram_rr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic               sel;
    logic               sel_we;
    logic               s1_vld;
    logic               s1_id;
    logic               s2_vld;
    logic               s2_id;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (req_valid),
        .grant (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign sel       = grant[1];
    assign sel_we    = sel ? req_we[1] : req_we[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            s1_vld   <= 1'b0;
            s1_id    <= 1'b0;
            s2_vld   <= 1'b0;
            s2_id    <= 1'b0;
        end else begin
            if (accept) begin
                ram_we   <= sel_we;
                ram_addr <= sel ? req_addr1 : req_addr0;
                ram_din  <= sel ? req_wdata1 : req_wdata0;
            end else begin
                ram_we   <= 1'b0;
            end
            // Tag rides alongside the command: stage1 with the RAM inputs,
            // stage2 with the RAM's registered output.
            s1_vld <= accept & ~sel_we;
            s1_id  <= sel;
            s2_vld <= s1_vld;
            s2_id  <= s1_id;
        end
    end

    always_comb begin
        rsp_valid = 2'b00;
        rsp_rdata = '0;
        if (s2_vld) begin
            rsp_valid = s2_id ? 2'b10 : 2'b01;
            rsp_rdata = ram_dout;
        end
    end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Self-checking bench: behavioural RAM behind the ram_* ports and a
// transaction-level reference model of arbitration and read returns.
module tb_ram_rr_arbiter;
    import ram_rr_arbiter_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [AW-1:0] req_addr0, req_addr1, ram_addr;
    logic [DW-1:0] req_wdata0, req_wdata1, rsp_rdata, ram_din, ram_dout;
    logic          ram_we;

    always #5 clk = ~clk;

    ram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    // Single-port synchronous RAM with a preload port for the bench.
    logic [DW-1:0] ram_mem [2**AW];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) ram_mem[pl_addr] <= pl_data;
        else if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    // Reference model: memory contents as of accept order, plus a queue of
    // expected read returns stamped with the cycle they are due.
    typedef struct {
        int           due;
        logic         id;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          pend[$];
    logic [DW-1:0] mdl_mem [2**AW];
    int            cyc = 0;
    int            last_gnt = 1;
    int            errors = 0;
    int            checks = 0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [1:0]    e_rdy, e_rsp;
    logic [DW-1:0] e_data;
    logic          e_we;

    task automatic model_eval();
        int g;
        logic [AW-1:0] a;
        e_rdy = 2'b00; e_rsp = 2'b00; e_data = '0; e_we = 1'b0;
        if (!rst_n) begin
            pend.delete();
            last_gnt = 1;
            m_we = 1'b0;
            cyc++;
            return;
        end
        e_we = m_we;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e_rsp  = pend[0].id ? 2'b10 : 2'b01;
            e_data = pend[0].data;
            void'(pend.pop_front());
        end
        g = -1;
        if (req_valid == 2'b11) g = 1 - last_gnt;
        else if (req_valid[0])  g = 0;
        else if (req_valid[1])  g = 1;
        m_we = 1'b0;
        if (g >= 0) begin
            e_rdy    = (g == 0) ? 2'b01 : 2'b10;
            last_gnt = g;
            a = (g == 0) ? req_addr0 : req_addr1;
            if (req_we[g]) begin
                m_we    = 1'b1;
                m_waddr = a;
                m_wdata = (g == 0) ? req_wdata0 : req_wdata1;
                mdl_mem[a] = m_wdata;
            end else begin
                pend.push_back('{due: cyc + RD_LAT, id: (g == 1), data: mdl_mem[a]});
            end
        end
        cyc++;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        req_valid = v; req_we = we;
        req_addr0 = a0; req_addr1 = a1;
        req_wdata0 = d0; req_wdata1 = d1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        mdl_mem[a] = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        drive(2'b11, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        @(negedge clk);
        model_eval();
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_gate ready: got %b exp 00", req_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            model_eval();
            if (i == 0) begin
                checks++;
                if (ram_addr !== '0 || ram_din !== '0) begin
                    errors++; $display("FAIL reset_vals addr/din: got %h/%h exp 0/0", ram_addr, ram_din);
                end
            end
            checks++; if (req_ready !== e_rdy) begin errors++; $display("FAIL idle ready: got %b exp %b", req_ready, e_rdy); end
            checks++; if (rsp_valid !== e_rsp) begin errors++; $display("FAIL idle rsp_valid: got %b exp %b", rsp_valid, e_rsp); end
            checks++; if (ram_we !== e_we) begin errors++; $display("FAIL idle ram_we: got %b exp %b", ram_we, e_we); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       drive(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00);
                1:       drive(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00);
                default: drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
            endcase
            @(negedge clk);
            model_eval();
            checks++; if (req_ready !== e_rdy) begin errors++; $display("FAIL wr_rd ready: got %b exp %b", req_ready, e_rdy); end
            checks++; if (rsp_valid !== e_rsp) begin errors++; $display("FAIL wr_rd rsp_valid: got %b exp %b", rsp_valid, e_rsp); end
            if (e_rsp != 2'b00) begin
                checks++; if (rsp_rdata !== e_data) begin errors++; $display("FAIL wr_rd rdata: got %h exp %h", rsp_rdata, e_data); end
            end
            checks++; if (ram_we !== e_we) begin errors++; $display("FAIL wr_rd ram_we: got %b exp %b", ram_we, e_we); end
            if (e_we) begin
                checks++;
                if (ram_addr !== m_waddr || ram_din !== m_wdata) begin
                    errors++; $display("FAIL wr_rd cmd: got %h/%h exp %h/%h", ram_addr, ram_din, m_waddr, m_wdata);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_contention();
        preload(4'd1, 8'h11);
        preload(4'd2, 8'h22);
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00);
            else       drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
            @(negedge clk);
            model_eval();
            checks++; if (req_ready !== e_rdy) begin errors++; $display("FAIL contend ready: got %b exp %b", req_ready, e_rdy); end
            checks++; if (rsp_valid !== e_rsp) begin errors++; $display("FAIL contend rsp_valid: got %b exp %b", rsp_valid, e_rsp); end
            if (e_rsp != 2'b00) begin
                checks++; if (rsp_rdata !== e_data) begin errors++; $display("FAIL contend rdata: got %h exp %h", rsp_rdata, e_data); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       drive(2'b10, 2'b10, 4'd0, 4'd15, 8'h00, 8'h5A);
                1:       drive(2'b01, 2'b00, 4'd15, 4'd0, 8'h00, 8'h00);
                default: drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
            endcase
            @(negedge clk);
            model_eval();
            checks++; if (req_ready !== e_rdy) begin errors++; $display("FAIL raw ready: got %b exp %b", req_ready, e_rdy); end
            checks++; if (rsp_valid !== e_rsp) begin errors++; $display("FAIL raw rsp_valid: got %b exp %b", rsp_valid, e_rsp); end
            if (e_rsp != 2'b00) begin
                checks++; if (rsp_rdata !== e_data) begin errors++; $display("FAIL raw rdata: got %h exp %h", rsp_rdata, e_data); end
            end
            checks++; if (ram_we !== e_we) begin errors++; $display("FAIL raw ram_we: got %b exp %b", ram_we, e_we); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       drive(2'b01, 2'b00, 4'd1, 4'd0, 8'h00, 8'h00);
                1:       begin rst_n = 1'b0; drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00); end
                4:       begin rst_n = 1'b1; drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00); end
                default: if (i > 4) drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
            endcase
            @(negedge clk);
            model_eval();
            checks++; if (req_ready !== e_rdy) begin errors++; $display("FAIL rst_mid ready: got %b exp %b", req_ready, e_rdy); end
            checks++; if (rsp_valid !== e_rsp) begin errors++; $display("FAIL rst_mid rsp_valid: got %b exp %b", rsp_valid, e_rsp); end
            if (e_rsp != 2'b00) begin
                checks++; if (rsp_rdata !== e_data) begin errors++; $display("FAIL rst_mid rdata: got %h exp %h", rsp_rdata, e_data); end
            end
            checks++; if (ram_we !== e_we) begin errors++; $display("FAIL rst_mid ram_we: got %b exp %b", ram_we, e_we); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [1:0] v;
        int wait_cnt [2];
        v = 2'b00;
        wait_cnt[0] = 0; wait_cnt[1] = 0;
        for (int c = 0; c < 1003; c++) begin
            if (c < 1000) begin
                // A pending request stays valid until granted; its command may change.
                for (int i = 0; i < 2; i++) begin
                    if (!(v[i] && wait_cnt[i] > 0)) v[i] = ($urandom_range(3) != 0);
                end
                drive(v, 2'($urandom_range(3)), 4'($urandom_range(15)), 4'($urandom_range(15)),
                      8'($urandom_range(255)), 8'($urandom_range(255)));
            end else begin
                v = 2'b00;
                drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
            end
            @(negedge clk);
            model_eval();
            checks++; if (req_ready !== e_rdy) begin errors++; $display("FAIL rand ready c%0d: got %b exp %b", c, req_ready, e_rdy); end
            checks++; if (rsp_valid !== e_rsp) begin errors++; $display("FAIL rand rsp_valid c%0d: got %b exp %b", c, rsp_valid, e_rsp); end
            if (e_rsp != 2'b00) begin
                checks++; if (rsp_rdata !== e_data) begin errors++; $display("FAIL rand rdata c%0d: got %h exp %h", c, rsp_rdata, e_data); end
            end
            checks++; if (ram_we !== e_we) begin errors++; $display("FAIL rand ram_we c%0d: got %b exp %b", c, ram_we, e_we); end
            for (int i = 0; i < 2; i++) begin
                wait_cnt[i] = (v[i] && !req_ready[i]) ? wait_cnt[i] + 1 : 0;
                if (v[i]) begin
                    checks++;
                    if (wait_cnt[i] > 1) begin errors++; $display("FAIL rand fairness req%0d: waited %0d cycles exp <=1", i, wait_cnt[i]); end
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        @(posedge clk); #1;
        for (int i = 0; i < 2**AW; i++) preload(AW'(i), 8'(i * 37 + 5));
        test_reset();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
